// File: rtl/gcn_pkg.sv
// gcn_pkg: shared constants and types for the GCN controller.
// Holds the matrix/graph dimensions, the memory map base for feature rows,
// the counter widths derived from those dimensions and the FSM state type.
package gcn_pkg;

  localparam int FEATURE_ROWS  = 6;
  localparam int WEIGHT_COLS   = 3;
  localparam int NUM_OF_EDGES  = 6;
  localparam int ADDRESS_WIDTH = 13;

  localparam logic [ADDRESS_WIDTH-1:0] FEATURE_BASE = 13'h200;

  // Counter widths; every index output is exactly one of these wide.
  localparam int ROW_W  = $clog2(FEATURE_ROWS);
  localparam int COL_W  = $clog2(WEIGHT_COLS);
  localparam int EDGE_W = $clog2(NUM_OF_EDGES);

  typedef enum logic [2:0] {
    IDLE,
    RD_WEIGHT,
    RD_FEATURE,
    FT_CAPTURE,
    MAC,
    AGGREGATE,
    ARGMAX,
    DONE
  } gcn_ctrl_state_t;

endpackage

// File: rtl/gcn_mod_counter.sv
// gcn_mod_counter: modulo-N phase counter.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   clear       - force the count to 0 on the next edge (wins over incr)
//   incr        - advance the count, wrapping to 0 after MODULUS-1
//   count_next  - value the count will hold after the next edge
//   terminal    - current count equals MODULUS-1
// The controller registers all of its outputs from next-cycle values, which
// is why the counter exposes its next count rather than its current one.
module gcn_mod_counter #(
  parameter int MODULUS = 3,
  parameter int WIDTH   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             incr,
  output logic [WIDTH-1:0] count_next,
  output logic             terminal
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next-count logic: clear has priority, increment wraps at the terminal value.
  always_comb begin
    terminal = (count_q == WIDTH'(MODULUS - 1));
    count_d  = count_q;
    if (clear) begin
      count_d = '0;
    end else if (incr) begin
      count_d = terminal ? '0 : count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_next = count_d;

endmodule

// File: rtl/gcn_controller.sv
// gcn_controller: sequencing FSM for a small GCN inference datapath.
// Reads the weight columns, then for each feature row reads and captures the
// row and runs one MAC per weight column, then walks the COO edge list for
// aggregation, then runs an argmax over every row and reports done.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   start           - level run request (sampled in IDLE and DONE)
//   read_address    - feature/weight memory address, enable_read strobe
//   coo_address     - COO column index during AGGREGATE
//   weight_wr_*     - capture strobe/column for the weight buffer
//   feature_wr_en   - capture strobe for the feature register
//   mac_*           - dot-product enable with row/column
//   agg_*           - COO data valid with its edge index
//   argmax_*        - argmax enable with row
//   busy, done      - run status
// Every output is a flop loaded from the value it must hold in the next cycle.
module gcn_controller
  import gcn_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  output logic                     enable_read,
  output logic [EDGE_W-1:0]        coo_address,
  output logic                     weight_wr_en,
  output logic [COL_W-1:0]         weight_wr_idx,
  output logic                     feature_wr_en,
  output logic                     mac_en,
  output logic [ROW_W-1:0]         mac_row,
  output logic [COL_W-1:0]         mac_col,
  output logic                     agg_en,
  output logic [EDGE_W-1:0]        agg_edge,
  output logic                     argmax_en,
  output logic [ROW_W-1:0]         argmax_row,
  output logic                     busy,
  output logic                     done
);

  gcn_ctrl_state_t state_q, state_d;
  logic            agg_drain_q, agg_drain_d;

  logic [ADDRESS_WIDTH-1:0] read_address_q, read_address_d;
  logic                     enable_read_q, enable_read_d;
  logic [EDGE_W-1:0]        coo_address_q, coo_address_d;
  logic                     weight_wr_en_q, weight_wr_en_d;
  logic [COL_W-1:0]         weight_wr_idx_q, weight_wr_idx_d;
  logic                     feature_wr_en_q, feature_wr_en_d;
  logic                     mac_en_q, mac_en_d;
  logic [ROW_W-1:0]         mac_row_q, mac_row_d;
  logic [COL_W-1:0]         mac_col_q, mac_col_d;
  logic                     agg_en_q, agg_en_d;
  logic [EDGE_W-1:0]        agg_edge_q, agg_edge_d;
  logic                     argmax_en_q, argmax_en_d;
  logic [ROW_W-1:0]         argmax_row_q, argmax_row_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic              cnt_clear;
  logic              w_incr, row_incr, col_incr, edge_incr, amax_incr;
  logic [COL_W-1:0]  w_next, col_next;
  logic [ROW_W-1:0]  row_next, amax_next;
  logic [EDGE_W-1:0] edge_next;
  logic              w_tc, row_tc, col_tc, edge_tc, amax_tc;

  // Counters are held at 0 while idle so every run starts from index 0.
  assign cnt_clear = (state_q == IDLE);
  assign w_incr    = (state_q == RD_WEIGHT);
  assign col_incr  = (state_q == MAC);
  assign row_incr  = (state_q == MAC) && col_tc;
  assign edge_incr = (state_q == AGGREGATE) && !agg_drain_q;
  assign amax_incr = (state_q == ARGMAX);

  gcn_mod_counter #(.MODULUS(WEIGHT_COLS), .WIDTH(COL_W)) u_weight_cnt (
    .clk(clk), .reset(reset), .clear(cnt_clear), .incr(w_incr),
    .count_next(w_next), .terminal(w_tc)
  );

  gcn_mod_counter #(.MODULUS(FEATURE_ROWS), .WIDTH(ROW_W)) u_row_cnt (
    .clk(clk), .reset(reset), .clear(cnt_clear), .incr(row_incr),
    .count_next(row_next), .terminal(row_tc)
  );

  gcn_mod_counter #(.MODULUS(WEIGHT_COLS), .WIDTH(COL_W)) u_col_cnt (
    .clk(clk), .reset(reset), .clear(cnt_clear), .incr(col_incr),
    .count_next(col_next), .terminal(col_tc)
  );

  gcn_mod_counter #(.MODULUS(NUM_OF_EDGES), .WIDTH(EDGE_W)) u_edge_cnt (
    .clk(clk), .reset(reset), .clear(cnt_clear), .incr(edge_incr),
    .count_next(edge_next), .terminal(edge_tc)
  );

  gcn_mod_counter #(.MODULUS(FEATURE_ROWS), .WIDTH(ROW_W)) u_argmax_cnt (
    .clk(clk), .reset(reset), .clear(cnt_clear), .incr(amax_incr),
    .count_next(amax_next), .terminal(amax_tc)
  );

  // Next-state logic. AGGREGATE needs one extra drain cycle after the last
  // COO address so the final edge's data can be flagged valid; agg_drain
  // marks that cycle.
  always_comb begin
    state_d     = state_q;
    agg_drain_d = agg_drain_q;
    case (state_q)
      IDLE:       if (start) state_d = RD_WEIGHT;
      RD_WEIGHT:  if (w_tc) state_d = RD_FEATURE;
      RD_FEATURE: state_d = FT_CAPTURE;
      FT_CAPTURE: state_d = MAC;
      MAC:        if (col_tc) state_d = row_tc ? AGGREGATE : RD_FEATURE;
      AGGREGATE: begin
        if (agg_drain_q) begin
          state_d     = ARGMAX;
          agg_drain_d = 1'b0;
        end else if (edge_tc) begin
          agg_drain_d = 1'b1;
        end
      end
      ARGMAX:     if (amax_tc) state_d = DONE;
      DONE:       if (!start) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Output decode for the coming cycle. Strobes tied to the upcoming state
  // use next counter values; the capture/valid strobes follow a one-cycle
  // memory latency, so their indices are simply last cycle's addresses.
  always_comb begin
    read_address_d  = '0;
    enable_read_d   = 1'b0;
    coo_address_d   = '0;
    weight_wr_en_d  = 1'b0;
    weight_wr_idx_d = '0;
    feature_wr_en_d = 1'b0;
    mac_en_d        = 1'b0;
    mac_row_d       = '0;
    mac_col_d       = '0;
    agg_en_d        = 1'b0;
    agg_edge_d      = '0;
    argmax_en_d     = 1'b0;
    argmax_row_d    = '0;
    busy_d          = (state_d != IDLE) && (state_d != DONE);
    done_d          = (state_d == DONE);

    case (state_d)
      RD_WEIGHT: begin
        enable_read_d  = 1'b1;
        read_address_d = ADDRESS_WIDTH'(w_next);
      end
      RD_FEATURE: begin
        enable_read_d  = 1'b1;
        read_address_d = FEATURE_BASE + ADDRESS_WIDTH'(row_next);
      end
      FT_CAPTURE: feature_wr_en_d = 1'b1;
      MAC: begin
        mac_en_d  = 1'b1;
        mac_row_d = row_next;
        mac_col_d = col_next;
      end
      AGGREGATE: if (!agg_drain_d) coo_address_d = edge_next;
      ARGMAX: begin
        argmax_en_d  = 1'b1;
        argmax_row_d = amax_next;
      end
      default: ;
    endcase

    if (state_q == RD_WEIGHT) begin
      weight_wr_en_d  = 1'b1;
      weight_wr_idx_d = read_address_q[COL_W-1:0];
    end
    if ((state_q == AGGREGATE) && !agg_drain_q) begin
      agg_en_d   = 1'b1;
      agg_edge_d = coo_address_q;
    end
  end

  // State and output registers; reset forces everything to 0 / IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      agg_drain_q     <= 1'b0;
      read_address_q  <= '0;
      enable_read_q   <= 1'b0;
      coo_address_q   <= '0;
      weight_wr_en_q  <= 1'b0;
      weight_wr_idx_q <= '0;
      feature_wr_en_q <= 1'b0;
      mac_en_q        <= 1'b0;
      mac_row_q       <= '0;
      mac_col_q       <= '0;
      agg_en_q        <= 1'b0;
      agg_edge_q      <= '0;
      argmax_en_q     <= 1'b0;
      argmax_row_q    <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      agg_drain_q     <= agg_drain_d;
      read_address_q  <= read_address_d;
      enable_read_q   <= enable_read_d;
      coo_address_q   <= coo_address_d;
      weight_wr_en_q  <= weight_wr_en_d;
      weight_wr_idx_q <= weight_wr_idx_d;
      feature_wr_en_q <= feature_wr_en_d;
      mac_en_q        <= mac_en_d;
      mac_row_q       <= mac_row_d;
      mac_col_q       <= mac_col_d;
      agg_en_q        <= agg_en_d;
      agg_edge_q      <= agg_edge_d;
      argmax_en_q     <= argmax_en_d;
      argmax_row_q    <= argmax_row_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign read_address  = read_address_q;
  assign enable_read   = enable_read_q;
  assign coo_address   = coo_address_q;
  assign weight_wr_en  = weight_wr_en_q;
  assign weight_wr_idx = weight_wr_idx_q;
  assign feature_wr_en = feature_wr_en_q;
  assign mac_en        = mac_en_q;
  assign mac_row       = mac_row_q;
  assign mac_col       = mac_col_q;
  assign agg_en        = agg_en_q;
  assign agg_edge      = agg_edge_q;
  assign argmax_en     = argmax_en_q;
  assign argmax_row    = argmax_row_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
